// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter for the CDC FIFO. It issues rd_fire, absorbs the
// FIFO's one-cycle read latency in a small circular skid buffer, and presents words
// downstream as a valid/ready stream with a packet-last flag and beat/packet counters.
module fifo_rd_stream #(
    parameter int unsigned DATA_W     = 65,
    parameter int unsigned SKID_DEPTH = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_fire,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-2:0] m_data,
    output logic              m_last,
    output logic [CNT_W-1:0]  beat_idx,
    output logic [CNT_W-1:0]  pkt_cnt
);

    localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(SKID_DEPTH + 1);
    localparam int unsigned SUM_W = OCC_W + 1;

    logic [DATA_W-1:0] skid_mem [SKID_DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [OCC_W-1:0]  occ_q;
    logic              inflight_q;

    logic              capture_c;
    logic              pop_c;
    logic [SUM_W-1:0]  reserved_c;
    logic [DATA_W-1:0] head_word_c;

    // Circular index increment, wrapping at SKID_DEPTH (need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        n = p + PTR_W'(1);
        if (p == PTR_W'(SKID_DEPTH - 1)) begin
            n = '0;
        end
        return n;
    endfunction

    // Fire decision from registered state only; each in-flight word holds a reserved slot.
    always_comb begin
        reserved_c   = SUM_W'(occ_q) + SUM_W'(inflight_q);
        fifo_rd_fire = !rst && !fifo_empty && (reserved_c < SUM_W'(SKID_DEPTH));
        capture_c    = inflight_q;
        m_valid      = (occ_q != '0);
        pop_c        = m_valid && m_ready;
        head_word_c  = skid_mem[head_q];
        m_data       = head_word_c[DATA_W-2:0];
        m_last       = head_word_c[DATA_W-1];
    end

    // Skid storage; contents are don't-care after reset, so no reset is applied.
    always_ff @(posedge clk) begin
        if (!rst && capture_c) begin
            skid_mem[tail_q] <= fifo_rd_data;
        end
    end

    // Occupancy, pointers and in-flight flag; a word in flight at reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            inflight_q <= fifo_rd_fire;
            if (capture_c) begin
                tail_q <= ptr_inc(tail_q);
            end
            if (pop_c) begin
                head_q <= ptr_inc(head_q);
            end
            case ({capture_c, pop_c})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Beat index within the packet and delivered-packet count, both advanced on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_idx <= '0;
            pkt_cnt  <= '0;
        end else if (pop_c) begin
            if (m_last) begin
                beat_idx <= '0;
                pkt_cnt  <= pkt_cnt + CNT_W'(1);
            end else begin
                beat_idx <= beat_idx + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: a queue-based FIFO model feeds the DUT, and a
// scoreboard of written words plus packet arithmetic predicts every delivered beat.
module tb_fifo_rd_stream;

    localparam int unsigned DATA_W = 65;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_fire;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-2:0] m_data;
    logic              m_last;
    logic [CNT_W-1:0]  beat_idx;
    logic [CNT_W-1:0]  pkt_cnt;

    fifo_rd_stream #(.DATA_W(DATA_W), .SKID_DEPTH(3), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_fire (fifo_rd_fire),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .beat_idx     (beat_idx),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] fq[$];     // contents of the modelled FIFO
    logic [DATA_W-1:0] sb[$];     // words expected downstream, in order
    int                tests = 0;
    int                fails = 0;
    int                cyc = 0;
    int                fires = 0;
    int                first_fire = -1;
    int                first_valid = -1;
    int                first_pop = -1;
    int                last_pop = -1;
    int                vcnt = 0;
    logic              hold_empty = 1'b0;
    logic              prev_hold = 1'b0;
    logic [DATA_W-1:0] prev_word = '0;
    logic [CNT_W-1:0]  exp_beat = '0;
    logic [CNT_W-1:0]  exp_pkts = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic last, input logic [DATA_W-2:0] payload);
        fq.push_back({last, payload});
        sb.push_back({last, payload});
    endtask

    // One clock: entered and left at negedge; inputs settle, outputs checked, FIFO modelled.
    task automatic cycle();
        logic              fire_seen;
        logic [DATA_W-1:0] exp_w;
        fifo_empty = hold_empty || (fq.size() == 0);
        #1;
        chk("fire_gate", fifo_rd_fire & (fifo_empty | rst), 1'b0);
        if (prev_hold) begin
            chk("hold_valid", m_valid, 1'b1);
            chk("hold_word", {m_last, m_data}, prev_word);
        end
        if (!rst && m_valid) begin
            if (first_valid < 0) first_valid = cyc;
            vcnt++;
        end
        if (!rst && m_valid && m_ready) begin
            chk("sb_nonempty", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                chk("data", {m_last, m_data}, exp_w);
                chk("beat_idx", beat_idx, exp_beat);
                chk("pkt_cnt", pkt_cnt, exp_pkts);
                if (exp_w[DATA_W-1]) begin
                    exp_beat = '0;
                    exp_pkts = exp_pkts + CNT_W'(1);
                end else begin
                    exp_beat = exp_beat + CNT_W'(1);
                end
            end
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        prev_hold = !rst && m_valid && !m_ready;
        prev_word = {m_last, m_data};
        fire_seen = fifo_rd_fire;
        if (fire_seen) begin
            fires++;
            if (first_fire < 0) first_fire = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (fire_seen) begin
            if (fq.size() != 0) fifo_rd_data = fq.pop_front();
            else fifo_rd_data = 'x;
        end
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && sb.size() != 0; n++) cycle();
        chk("drained", sb.size(), 0);
    endtask

    initial begin
        int npk;
        int total;
        int len;
        logic [CNT_W-1:0] pkt_base;

        // Reset held with a non-empty FIFO; single 4-beat packet behind it.
        rst = 1'b1; m_ready = 1'b1; fifo_rd_data = '0; fifo_empty = 1'b0;
        for (int i = 1; i <= 4; i++) push_word(i == 4, (DATA_W-1)'(i));
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            fifo_empty = 1'b0;
            #1;
            chk("rst_fire", fifo_rd_fire, 1'b0);
            chk("rst_valid", m_valid, 1'b0);
            chk("rst_pkt", pkt_cnt, 0);
            chk("rst_beat", beat_idx, 0);
            cycle();
        end
        rst = 1'b0;
        #1;
        chk("fire_after_rst", fifo_rd_fire, 1'b1);
        first_fire = -1; first_valid = -1; first_pop = -1; last_pop = -1;
        drain(40);
        chk("fire_to_valid", first_valid - first_fire, 2);
        chk("burst_span", last_pop - first_pop, 3);
        chk("pkt_after_single", pkt_cnt, 1);

        // Full backpressure: 8 words, ready low for 10 cycles.
        for (int i = 0; i < 8; i++) push_word(i == 7, (DATA_W-1)'(16'hA0 + i));
        m_ready = 1'b0; fires = 0;
        for (int i = 0; i < 10; i++) cycle();
        chk("bp_fires", fires, 3);
        chk("bp_fire_low", fifo_rd_fire, 1'b0);
        chk("bp_head", {m_last, m_data}, sb[0]);
        m_ready = 1'b1;
        cycle();
        chk("bp_refire", fifo_rd_fire, 1'b1);
        drain(40);
        chk("pkt_after_bp", pkt_cnt, 2);

        // Random ready and random FIFO empty gaps, 200 words in packets of 1..7.
        npk = 0; total = 0; pkt_base = exp_pkts;
        while (total < 200) begin
            len = $urandom_range(1, 7);
            if (total + len > 200) len = 200 - total;
            for (int b = 0; b < len; b++) push_word(b == len - 1, {$urandom, $urandom});
            total += len;
            npk++;
        end
        for (int n = 0; n < 4000 && sb.size() != 0; n++) begin
            m_ready = 1'($urandom_range(0, 1));
            hold_empty = ($urandom_range(0, 3) == 0);
            cycle();
        end
        chk("rand_drained", sb.size(), 0);
        chk("rand_pkts", pkt_cnt, pkt_base + CNT_W'(npk));
        hold_empty = 1'b0; m_ready = 1'b1;

        // Empty starvation: FIFO flips between empty and non-empty every cycle.
        for (int i = 0; i < 20; i++) push_word(i % 5 == 4, (DATA_W-1)'(16'h500 + i));
        vcnt = 0;
        for (int n = 0; n < 200 && sb.size() != 0; n++) begin
            hold_empty = n[0];
            cycle();
        end
        chk("starve_drained", sb.size(), 0);
        chk("starve_valid_cycles", vcnt, 20);
        hold_empty = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // Mid-stream reset with two buffered words and one in flight, beat_idx at 1.
        for (int i = 0; i < 6; i++) push_word(1'b0, (DATA_W-1)'(16'h700 + i));
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        m_ready = 1'b1;
        cycle();
        m_ready = 1'b0;
        cycle();
        chk("pre_rst_beat", beat_idx, 1);
        chk("pre_rst_valid", m_valid, 1'b1);
        rst = 1'b1;
        fq.delete(); sb.delete();
        exp_beat = '0; exp_pkts = '0;
        cycle();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", m_valid, 1'b0);
        chk("mid_rst_pkt", pkt_cnt, 0);
        chk("mid_rst_beat", beat_idx, 0);
        for (int i = 0; i < 3; i++) cycle();
        chk("mid_rst_idle", m_valid, 1'b0);
        push_word(1'b0, (DATA_W-1)'(64'hDEAD_0001));
        push_word(1'b1, (DATA_W-1)'(64'hDEAD_0002));
        m_ready = 1'b1;
        drain(40);
        for (int i = 0; i < 4; i++) cycle();
        chk("post_rst_pkt", pkt_cnt, 1);
        chk("post_rst_idle", m_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Single-clock read-side adapter for the clock-domain-crossing FIFO. It drives the FIFO's `rd_fire`, absorbs the FIFO's one-cycle registered read latency in a small skid buffer, and presents the words downstream as a valid/ready stream with a packet-last flag. It sits entirely in the read clock domain and sustains one word per cycle when the FIFO is non-empty and downstream is ready.

## Interface
- `DATA_W`, 65, FIFO word width; bit `DATA_W-1` is the packet-last flag, bits `DATA_W-2:0` are payload.
- `SKID_DEPTH`, 3, output buffer entries; legal range 3..8.
- `CNT_W`, 16, width of the beat and packet counters.

- `clk`  in  1  read-domain clock; same clock as the FIFO `rd_clk`.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  FIFO `empty`, in the `clk` domain.
- `fifo_rd_data`  in  DATA_W  FIFO `rd_data`; valid on the cycle after a fire.
- `fifo_rd_fire`  out  1  read strobe to the FIFO.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DATA_W-1  payload of the head entry.
- `m_last`  out  1  last flag of the head entry.
- `beat_idx`  out  CNT_W  index of the head beat within its packet; 0 for the first beat.
- `pkt_cnt`  out  CNT_W  count of packets fully delivered; wraps modulo 2^CNT_W.

## Operation
- **State.**
  - `occ` counts valid skid entries, 0..SKID_DEPTH.
  - `inflight` is a 1-bit flag: a fire was issued last cycle.
  - The skid storage is a circular buffer with `head`/`tail` indices that wrap at SKID_DEPTH.
- **Fire rule.** `fifo_rd_fire = !rst && !fifo_empty && (occ + inflight < SKID_DEPTH)`.
  - The rule uses registered state only. `m_ready` is not in the path.
  - Never fire while `fifo_empty` is high; the FIFO would ignore it and the capture would be corrupt.
- **Capture.** When `inflight` is 1, write `fifo_rd_data` at `tail` and advance `tail`. `inflight` is then set to the current `fifo_rd_fire`.
- **Pop.** The condition is `m_valid && m_ready`. `head` advances.
- **Occupancy.** `occ` next = `occ + capture − pop`. Simultaneous capture and pop leaves `occ` unchanged. `occ` can never exceed SKID_DEPTH, because the fire rule reserves a slot for every in-flight word.
- **Output.** `m_valid = (occ != 0)`. `{m_last, m_data}` is the entry at `head`.
  - Output is stable while `m_valid && !m_ready`.
  - `m_valid` never drops without a pop.
- **Counters.**
  - On pop with `m_last = 1`: `beat_idx` goes to 0 and `pkt_cnt` increments.
  - On pop with `m_last = 0`: `beat_idx` increments and wraps modulo 2^CNT_W.
- **Reset.** `rst` zeroes `occ`, `inflight`, `head`, `tail`, `beat_idx` and `pkt_cnt`.
  - Skid contents are don't-care.
  - A word in flight at reset is discarded.
  - `rst` must be asserted together with the FIFO's reset, so the pointers stay coherent.

## Timing
- **Reset values.** `fifo_rd_fire`=0, `m_valid`=0, `beat_idx`=0, `pkt_cnt`=0. `m_data`/`m_last` are undefined while `m_valid`=0.
- **Latency.** From `fifo_empty` falling to `fifo_rd_fire`: 0 cycles (combinational). From the fire to `m_valid`: 2 cycles. Cycle N fires; N+1 the FIFO presents data and capture occurs; N+2 `m_valid`=1.
- **Throughput.** With `m_ready` held at 1 and the FIFO never empty: one pop per cycle after fill, and `fire` stays high every cycle.
- **Backpressure.** With `m_ready`=0, fires continue until `occ + inflight` = SKID_DEPTH. Exactly SKID_DEPTH words are then buffered and `fire` stays at 0. When `m_ready` returns, `fire` re-asserts in the same cycle the first pop lowers `occ`, as seen next cycle via the registered state.
- **Simultaneous events.**
  - Capture, pop and fire may coincide in one cycle.
  - Pop of the last entry plus capture in the same cycle keeps `m_valid`=1 with the new word.
  - Reset overrides all other events.

## Test plan
- **Reset:** hold `rst` 3 cycles with `fifo_empty`=0 → `fifo_rd_fire`=0, `m_valid`=0, `pkt_cnt`=0 throughout; first fire on the cycle `rst` deasserts.
- **Single packet:** the FIFO supplies 4 words 0x1..0x4, last set on 0x4, `m_ready`=1 → `m_data` shows 1,2,3,4 on consecutive cycles; `beat_idx` shows 0,1,2,3; `m_last` is 1 only on the 4th beat; `pkt_cnt` goes to 1 afterwards; the first `m_valid` appears 2 cycles after the first fire.
- **Full backpressure:** FIFO holds 8 words, `m_ready`=0 for 10 cycles → exactly 3 fires, `occ`=3, `m_data` stays on word 0. Then `m_ready`=1 → 8 words delivered in order with no duplicates or drops.
- **Random ready:** `m_ready` toggles randomly at 50%, 200 words, packet lengths 1–7 → output sequence equals input; `pkt_cnt` equals the number of packets; a fire never occurs while `fifo_empty`=1.
- **Empty starvation:** the FIFO alternates empty and non-empty every cycle → at most one fire per non-empty cycle; `m_valid` gaps match the supply; no word is lost.
- **Mid-stream reset:** `rst` pulsed for 1 cycle with `occ`=2 and `inflight`=1 → the next cycle shows `m_valid`=0, `pkt_cnt`=0, `beat_idx`=0; after the FIFO is also reset, a fresh 2-word packet is delivered correctly.
